// File: rtl/cdb_arbiter_pkg.sv
// Shared RV32I types for the common data bus: FU result payload and FU indices.
package rv32i_types;

  localparam int NUM_FU_CDB = 4;

  localparam int FU_ALU = 0;
  localparam int FU_BR  = 1;
  localparam int FU_MUL = 2;
  localparam int FU_LSU = 3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] rd_wdata;
  } rvfi_data_t;

  typedef struct packed {
    logic [5:0]  pd_s;
    logic [31:0] pd_v;
    logic [3:0]  rob_num;
    logic        br_en;
    logic        br_taken;
    logic [31:0] br_target;
    rvfi_data_t  rvfi_data;
  } fu_cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [PTR_W-1:0] idx;

  // Walk the request vector from ptr with wrap-around; the first hit is granted.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PTR_W'((32'(ptr) + i) % N);
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any_gnt  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one finished FU per cycle and registers its result onto the CDB.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter  int NUM_FU = NUM_FU_CDB,
  localparam int PTR_W  = $clog2(NUM_FU)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_mispredict,
  input  logic [NUM_FU-1:0] fu_done,
  input  fu_cdb_data_t     fu_data [NUM_FU],
  output logic [NUM_FU-1:0] cdb_ack,
  output logic             cdb_valid,
  output fu_cdb_data_t     cdb_data,
  output logic [PTR_W-1:0] fu_grant_idx
);

  logic [NUM_FU-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic              fire;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  fu_cdb_data_t      cdb_data_q, cdb_data_d;
  logic [PTR_W-1:0]  grant_idx_q, grant_idx_d;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req     (fu_done),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Suppress the grant during reset/flush; on a grant, capture the winner and rotate priority past it.
  always_comb begin
    fire        = any_gnt && !rst && !branch_mispredict;
    cdb_ack     = fire ? gnt : '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = fire;
    cdb_data_d  = cdb_data_q;
    grant_idx_d = grant_idx_q;
    if (fire) begin
      cdb_data_d  = fu_data[gnt_idx];
      grant_idx_d = gnt_idx;
      rr_ptr_d    = (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // Pointer and CDB output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      grant_idx_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  // Registered outputs straight from the flops.
  always_comb begin
    cdb_valid    = cdb_valid_q;
    cdb_data     = cdb_data_q;
    fu_grant_idx = grant_idx_q;
  end

endmodule
